controle_jogada: RTL and testbench
==================================

# controle_jogada

Game-move sequencer for the Sudoku datapath. It sits directly upstream of the input-capture stage. It debounces the raw Enter and Cancel push-buttons and runs the move state machine (row → column → value → write). It drives `estadoJogo` and a single-cycle `keyEnter` pulse, which the input-capture stage uses to steer the switch value into the row, column or value register. It also hands the finished move to the board memory through a request/acknowledge handshake.

## Interface
Parameters:
- `DEBOUNCE_CICLOS`, default 500000: consecutive stable cycles required to accept a key level (10 ms at 50 MHz).
- `ERRO_CICLOS`, default 50000000: cycles spent in the error state (1 s at 50 MHz).

Ports:
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `keyEnterRaw` input 1: raw Enter button, active-low, asynchronous to `clk`.
- `keyCancelaRaw` input 1: raw Cancel button, active-low, asynchronous to `clk`.
- `ackGravacao` input 1: board memory has completed the write.
- `celulaFixa` input 1: target cell is a fixed clue. Valid in the cycle `ackGravacao`=1.
- `tabuleiroCompleto` input 1: board is full and valid. Valid in the cycle `ackGravacao`=1.
- `estadoJogo` output 3: current move state, encoding below.
- `keyEnter` output 1: one-cycle accepted-Enter pulse.
- `enableEntrada` output 1: high in the input states; this is the input-capture stage's `enable`.
- `pedidoGravacao` output 1: write request to board memory.
- `erroJogada` output 1: high while in ERRO.
- `fimJogo` output 1: high while in FIM.

## Operation
States and `estadoJogo` encoding (shared with the input-capture stage):
- LINHA=000, COLUNA=001, VALOR=011, GRAVA=010, ERRO=110, FIM=111.

Debounce:
- Each raw key passes through a 2-flop synchroniser, then a stability counter.
- The accepted level changes only after the synchronised level has differed from it for `DEBOUNCE_CICLOS` consecutive cycles. Any bounce restarts the count.
- A press (accepted level 1→0) produces one press event. Releases produce nothing.

Event filtering:
- Enter events are forwarded as `keyEnter`=1 for exactly one cycle, only in LINHA, COLUNA or VALOR. They are discarded in every other state.
- When Enter and Cancel events occur in the same cycle, Cancel wins and `keyEnter` stays 0.

Transitions (registered; take effect the cycle after the event):
- LINHA: Enter → COLUNA. Cancel is ignored.
- COLUNA: Enter → VALOR. Cancel → LINHA.
- VALOR: Enter → GRAVA. Cancel → LINHA.
- GRAVA: `pedidoGravacao`=1 until `ackGravacao`=1. On the ack cycle the next state is:
  - ERRO if `celulaFixa`=1 (takes priority);
  - otherwise FIM if `tabuleiroCompleto`=1;
  - otherwise LINHA.
- ERRO: timer loaded with `ERRO_CICLOS`-1 on entry. Return to LINHA when the timer reaches 0. Key events are ignored.
- FIM: terminal; left only by `reset`.

Other rules:
- `enableEntrada` = 1 in LINHA, COLUNA and VALOR, and 0 elsewhere.
- Unused encodings (100, 101) go to LINHA on the next cycle.

## Timing
Reset values:
- `estadoJogo`=000, `keyEnter`=0, `enableEntrada`=1, `pedidoGravacao`=0, `erroJogada`=0, `fimJogo`=0.
- Synchronisers and accepted levels reset to 1 (released). Counters and timer reset to 0.

Latency and cycle relationships:
- Raw press held steadily from cycle N: `keyEnter` is high in cycle N+2+`DEBOUNCE_CICLOS`.
- `estadoJogo` still shows the old state in the `keyEnter` cycle and shows the new state one cycle later. The input-capture stage samples both in the same cycle.
- `pedidoGravacao` rises in the first GRAVA cycle and falls in the cycle after the ack.
- The ack is honoured in any GRAVA cycle, including the first one.
- ERRO lasts exactly `ERRO_CICLOS` cycles.

Reset behaviour:
- Reset mid-operation (including mid-GRAVA with a request outstanding) returns to LINHA immediately.
- `pedidoGravacao` drops asynchronously; no ack is awaited.
- A key held through reset release generates no event until it is released and pressed again.

## Structure
- Shared package: state encoding constants LINHA/COLUNA/VALOR/GRAVA/ERRO/FIM, used by this block and the input-capture stage.
- Sub-module `debounce_tecla`: synchroniser, stability counter and press-pulse generator, parameterised by `DEBOUNCE_CICLOS`. Instantiated twice, once for Enter and once for Cancel.
- Top-level holds the state register, event filtering, ERRO timer and output decode.

## Test plan
All scenarios use `DEBOUNCE_CICLOS`=4 and `ERRO_CICLOS`=8.
- Clean Enter press in LINHA: one `keyEnter` pulse 6 cycles after the press; `estadoJogo` goes 000 → 001 the following cycle.
- Bouncing input (0,1,0,1 then steady 0): exactly one pulse, counted from the last edge. A 3-cycle glitch produces no pulse.
- Full move Enter×3 with `ackGravacao` 5 cycles after entering GRAVA, `celulaFixa`=0, `tabuleiroCompleto`=0: state sequence 000, 001, 011, 010, 000; `pedidoGravacao` high for 6 cycles.
- Ack with `celulaFixa`=1: ERRO (110) with `erroJogada`=1 for 8 cycles, then 000. Enter presses during ERRO give `keyEnter`=0.
- Cancel in VALOR → 000. Simultaneous Enter+Cancel in COLUNA → 000 with no `keyEnter`. Ack with `tabuleiroCompleto`=1 → 111, held until `reset`.
- `reset` asserted mid-GRAVA: outputs go to their reset values asynchronously. A key held across reset release gives no pulse.

Source files
------------

// File: rtl/controle_jogada_pkg.sv
// Shared move-state encoding for the move sequencer and the input-capture stage.
// The values are fixed because the capture stage decodes estadoJogo directly.
package controle_jogada_pkg;

  typedef enum logic [2:0] {
    LINHA  = 3'b000,
    COLUNA = 3'b001,
    VALOR  = 3'b011,
    GRAVA  = 3'b010,
    ERRO   = 3'b110,
    FIM    = 3'b111
  } estado_t;

  // True in the states where the player is entering row, column or value.
  function automatic logic eh_entrada(input logic [2:0] e);
    return (e == LINHA) || (e == COLUNA) || (e == VALOR);
  endfunction

endpackage

// File: rtl/controle_jogada_if.sv
// Request/acknowledge handshake between the move sequencer and the board memory.
interface controle_jogada_if;
  logic pedidoGravacao;
  logic ackGravacao;
  logic celulaFixa;
  logic tabuleiroCompleto;

  modport master (
    output pedidoGravacao,
    input  ackGravacao,
    input  celulaFixa,
    input  tabuleiroCompleto
  );

  modport slave (
    input  pedidoGravacao,
    output ackGravacao,
    output celulaFixa,
    output tabuleiroCompleto
  );
endinterface

// File: rtl/controle_jogada_debounce_tecla.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted 1->0 transition of the active-low key.
module debounce_tecla #(
  parameter int DEBOUNCE_CICLOS = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic tecla,
  output logic pressao
);

  localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic          sinc1_reg;
  logic          sinc2_reg;
  logic          nivel_reg;
  logic [CW-1:0] cont_reg;
  logic [1:0]    inic_reg;
  logic          armado_reg;

  logic diferente;
  logic estavel;

  assign diferente = (sinc2_reg != nivel_reg);
  assign estavel   = diferente && (cont_reg == CONT_MAX);
  // A key held through reset never arms, so its first accepted low is swallowed.
  assign pressao   = estavel && !sinc2_reg && armado_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sinc1_reg  <= 1'b1;
      sinc2_reg  <= 1'b1;
      nivel_reg  <= 1'b1;
      cont_reg   <= '0;
      inic_reg   <= 2'd0;
      armado_reg <= 1'b0;
    end else begin
      sinc1_reg <= tecla;
      sinc2_reg <= sinc1_reg;
      if (inic_reg != 2'd2)
        inic_reg <= inic_reg + 2'd1;
      // Arm only once the synchroniser carries real samples showing the key released.
      if (inic_reg == 2'd2 && sinc2_reg)
        armado_reg <= 1'b1;
      if (!diferente) begin
        cont_reg <= '0;
      end else if (estavel) begin
        nivel_reg <= sinc2_reg;
        cont_reg  <= '0;
      end else begin
        cont_reg <= cont_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/controle_jogada.sv
// Sudoku move sequencer: debounces Enter/Cancel, walks row -> column -> value -> write,
// and hands the finished move to the board memory over a request/ack handshake.
module controle_jogada
  import controle_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int ERRO_CICLOS     = 50000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      keyEnterRaw,
  input  logic                      keyCancelaRaw,
  controle_jogada_if.master         mem,
  output logic [2:0]                estadoJogo,
  output logic                      keyEnter,
  output logic                      enableEntrada,
  output logic                      erroJogada,
  output logic                      fimJogo
);

  localparam int TW = (ERRO_CICLOS > 1) ? $clog2(ERRO_CICLOS) : 1;
  localparam logic [TW-1:0] ERRO_CARGA = TW'(ERRO_CICLOS - 1);

  logic          ev_enter;
  logic          ev_cancela;

  logic [2:0]    estado_reg;
  logic [2:0]    estado_next;
  logic [TW-1:0] timer_reg;
  logic          keyEnter_reg;
  logic          cancela_reg;
  logic          pedido_reg;
  logic          enable_reg;
  logic          erro_reg;
  logic          fim_reg;

  debounce_tecla #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_enter (
    .clk     (clk),
    .reset   (reset),
    .tecla   (keyEnterRaw),
    .pressao (ev_enter)
  );

  debounce_tecla #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_cancela (
    .clk     (clk),
    .reset   (reset),
    .tecla   (keyCancelaRaw),
    .pressao (ev_cancela)
  );

  // keyEnter_reg is already cleared when Cancel arrived together, so Cancel wins.
  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      LINHA:  if (keyEnter_reg) estado_next = COLUNA;
      COLUNA: begin
        if (cancela_reg)       estado_next = LINHA;
        else if (keyEnter_reg) estado_next = VALOR;
      end
      VALOR: begin
        if (cancela_reg)       estado_next = LINHA;
        else if (keyEnter_reg) estado_next = GRAVA;
      end
      GRAVA: begin
        if (mem.ackGravacao) begin
          if (mem.celulaFixa)             estado_next = ERRO;
          else if (mem.tabuleiroCompleto) estado_next = FIM;
          else                            estado_next = LINHA;
        end
      end
      ERRO:    if (timer_reg == '0) estado_next = LINHA;
      FIM:     estado_next = FIM;
      default: estado_next = LINHA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_reg   <= LINHA;
      timer_reg    <= '0;
      keyEnter_reg <= 1'b0;
      cancela_reg  <= 1'b0;
      pedido_reg   <= 1'b0;
      enable_reg   <= 1'b1;
      erro_reg     <= 1'b0;
      fim_reg      <= 1'b0;
    end else begin
      estado_reg   <= estado_next;
      keyEnter_reg <= ev_enter && !ev_cancela && eh_entrada(estado_reg);
      cancela_reg  <= ev_cancela;
      if (estado_next == ERRO && estado_reg != ERRO)
        timer_reg <= ERRO_CARGA;
      else if (estado_reg == ERRO && timer_reg != '0)
        timer_reg <= timer_reg - 1'b1;
      // Outputs are decoded from the next state so they align with estadoJogo.
      pedido_reg <= (estado_next == GRAVA);
      enable_reg <= eh_entrada(estado_next);
      erro_reg   <= (estado_next == ERRO);
      fim_reg    <= (estado_next == FIM);
    end
  end

  assign estadoJogo         = estado_reg;
  assign keyEnter           = keyEnter_reg;
  assign enableEntrada      = enable_reg;
  assign erroJogada         = erro_reg;
  assign fimJogo            = fim_reg;
  assign mem.pedidoGravacao = pedido_reg;

endmodule

// File: tb/tb_controle_jogada.sv
// Directed bench for controle_jogada with DEBOUNCE_CICLOS=4 and ERRO_CICLOS=8.
module tb_controle_jogada;

  localparam int OP_ENTER  = 0;
  localparam int OP_CANCEL = 1;
  localparam int OP_BOTH   = 2;
  localparam int OP_ACK    = 3;
  localparam int OP_ERRO   = 4;

  typedef struct {
    int         op;
    int         atraso;
    logic       fixa;
    logic       completo;
    logic       pulso;
    logic [2:0] est;
  } passo_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       keyEnterRaw = 1'b1;
  logic       keyCancelaRaw = 1'b1;
  logic [2:0] estadoJogo;
  logic       keyEnter;
  logic       enableEntrada;
  logic       erroJogada;
  logic       fimJogo;

  int         checks = 0;
  int         failures = 0;
  logic [2:0] est_esp = 3'b000;
  passo_t     tabela [19];

  controle_jogada_if mem_if ();

  controle_jogada #(.DEBOUNCE_CICLOS(4), .ERRO_CICLOS(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .keyEnterRaw   (keyEnterRaw),
    .keyCancelaRaw (keyCancelaRaw),
    .mem           (mem_if.master),
    .estadoJogo    (estadoJogo),
    .keyEnter      (keyEnter),
    .enableEntrada (enableEntrada),
    .erroJogada    (erroJogada),
    .fimJogo       (fimJogo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_estado", 32'(estadoJogo), 32'h0);
    chk("rst_keyEnter", 32'(keyEnter), 32'h0);
    chk("rst_enable", 32'(enableEntrada), 32'h1);
    chk("rst_pedido", 32'(mem_if.pedidoGravacao), 32'h0);
    chk("rst_erro", 32'(erroJogada), 32'h0);
    chk("rst_fim", 32'(fimJogo), 32'h0);
  endtask

  // Press from cycle N; pulse expected in N+6, new state in N+7.
  task automatic pressiona(input logic e, input logic c, input logic pulso, input logic [2:0] est);
    repeat (8) tick();
    keyEnterRaw   = e ? 1'b0 : 1'b1;
    keyCancelaRaw = c ? 1'b0 : 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("keyEnter_early", 32'(keyEnter), 32'h0);
      tick();
    end
    chk("keyEnter_pulse", 32'(keyEnter), 32'(pulso));
    chk("estado_hold", 32'(estadoJogo), 32'(est_esp));
    tick();
    chk("keyEnter_single", 32'(keyEnter), 32'h0);
    chk("estado_next", 32'(estadoJogo), 32'(est));
    est_esp       = est;
    keyEnterRaw   = 1'b1;
    keyCancelaRaw = 1'b1;
  endtask

  // Entered on the first GRAVA cycle; ack raised 'atraso' cycles later.
  task automatic grava(input int atraso, input logic fixa, input logic completo, input logic [2:0] est);
    for (int k = 0; k < atraso; k++) begin
      chk("pedido_wait", 32'(mem_if.pedidoGravacao), 32'h1);
      chk("estado_grava", 32'(estadoJogo), 32'h2);
      tick();
    end
    mem_if.ackGravacao       = 1'b1;
    mem_if.celulaFixa        = fixa;
    mem_if.tabuleiroCompleto = completo;
    chk("pedido_ack", 32'(mem_if.pedidoGravacao), 32'h1);
    tick();
    mem_if.ackGravacao       = 1'b0;
    mem_if.celulaFixa        = 1'b0;
    mem_if.tabuleiroCompleto = 1'b0;
    chk("pedido_drop", 32'(mem_if.pedidoGravacao), 32'h0);
    chk("estado_pos_ack", 32'(estadoJogo), 32'(est));
    chk("erro_pos_ack", 32'(erroJogada), (est == 3'b110) ? 32'h1 : 32'h0);
    chk("fim_pos_ack", 32'(fimJogo), (est == 3'b111) ? 32'h1 : 32'h0);
    est_esp = est;
  endtask

  // Entered on the first ERRO cycle; an Enter press inside ERRO must be dropped.
  task automatic erro_seq();
    for (int k = 0; k < 8; k++) begin
      if (k == 0) keyEnterRaw = 1'b0;
      chk("erro_estado", 32'(estadoJogo), 32'h6);
      chk("erro_flag", 32'(erroJogada), 32'h1);
      chk("erro_keyEnter", 32'(keyEnter), 32'h0);
      chk("erro_enable", 32'(enableEntrada), 32'h0);
      tick();
    end
    chk("erro_exit_estado", 32'(estadoJogo), 32'h0);
    chk("erro_exit_flag", 32'(erroJogada), 32'h0);
    chk("erro_exit_enable", 32'(enableEntrada), 32'h1);
    chk("erro_exit_keyEnter", 32'(keyEnter), 32'h0);
    keyEnterRaw = 1'b1;
    est_esp = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bounce [4];
    bounce = '{1'b0, 1'b1, 1'b0, 1'b1};

    tabela[0]  = '{OP_BOTH,   0, 1'b0, 1'b0, 1'b0, 3'b000};
    tabela[1]  = '{OP_CANCEL, 0, 1'b0, 1'b0, 1'b0, 3'b000};
    tabela[2]  = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b001};
    tabela[3]  = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b011};
    tabela[4]  = '{OP_CANCEL, 0, 1'b0, 1'b0, 1'b0, 3'b000};
    tabela[5]  = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b001};
    tabela[6]  = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b011};
    tabela[7]  = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b010};
    tabela[8]  = '{OP_ACK,    5, 1'b0, 1'b0, 1'b0, 3'b000};
    tabela[9]  = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b001};
    tabela[10] = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b011};
    tabela[11] = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b010};
    tabela[12] = '{OP_ACK,    0, 1'b1, 1'b1, 1'b0, 3'b110};
    tabela[13] = '{OP_ERRO,   0, 1'b0, 1'b0, 1'b0, 3'b000};
    tabela[14] = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b001};
    tabela[15] = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b011};
    tabela[16] = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b1, 3'b010};
    tabela[17] = '{OP_ACK,    2, 1'b0, 1'b1, 1'b0, 3'b111};
    tabela[18] = '{OP_ENTER,  0, 1'b0, 1'b0, 1'b0, 3'b111};

    mem_if.ackGravacao       = 1'b0;
    mem_if.celulaFixa        = 1'b0;
    mem_if.tabuleiroCompleto = 1'b0;

    repeat (3) tick();
    chk_reset();
    reset = 1'b0;
    $display("reset released, estado=%b", estadoJogo);

    // Bouncing Enter: pulse counted from the last edge of the bounce.
    repeat (8) tick();
    for (int k = 0; k < 4; k++) begin
      keyEnterRaw = bounce[k];
      chk("bounce_quiet", 32'(keyEnter), 32'h0);
      tick();
    end
    keyEnterRaw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("bounce_early", 32'(keyEnter), 32'h0);
      tick();
    end
    chk("bounce_pulse", 32'(keyEnter), 32'h1);
    chk("bounce_estado_hold", 32'(estadoJogo), 32'h0);
    tick();
    chk("bounce_single", 32'(keyEnter), 32'h0);
    chk("bounce_estado", 32'(estadoJogo), 32'h1);
    keyEnterRaw = 1'b1;
    est_esp = 3'b001;
    $display("bounce press done, estado=%b", estadoJogo);

    // 3-cycle glitch is one short of the debounce window.
    repeat (8) tick();
    keyEnterRaw = 1'b0;
    repeat (3) tick();
    keyEnterRaw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("glitch_keyEnter", 32'(keyEnter), 32'h0);
      tick();
    end
    chk("glitch_estado", 32'(estadoJogo), 32'h1);
    $display("glitch done, estado=%b", estadoJogo);

    for (int i = 0; i < 19; i++) begin
      case (tabela[i].op)
        OP_ENTER:  pressiona(1'b1, 1'b0, tabela[i].pulso, tabela[i].est);
        OP_CANCEL: pressiona(1'b0, 1'b1, tabela[i].pulso, tabela[i].est);
        OP_BOTH:   pressiona(1'b1, 1'b1, tabela[i].pulso, tabela[i].est);
        OP_ACK:    grava(tabela[i].atraso, tabela[i].fixa, tabela[i].completo, tabela[i].est);
        default:   erro_seq();
      endcase
      $display("step %0d op=%0d estado=%b keyEnter=%b pedido=%b", i, tabela[i].op,
               estadoJogo, keyEnter, mem_if.pedidoGravacao);
    end

    // FIM holds until reset.
    repeat (10) tick();
    chk("fim_hold", 32'(estadoJogo), 32'h7);
    reset = 1'b1;
    tick();
    chk_reset();
    reset = 1'b0;
    est_esp = 3'b000;
    $display("reset from FIM, estado=%b", estadoJogo);

    // Reset mid-GRAVA with request outstanding, Enter held across reset release.
    pressiona(1'b1, 1'b0, 1'b1, 3'b001);
    pressiona(1'b1, 1'b0, 1'b1, 3'b011);
    pressiona(1'b1, 1'b0, 1'b1, 3'b010);
    chk("grava_pedido", 32'(mem_if.pedidoGravacao), 32'h1);
    #2;
    reset = 1'b1;
    keyEnterRaw = 1'b0;
    #1;
    chk_reset();
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("held_keyEnter", 32'(keyEnter), 32'h0);
      chk("held_estado", 32'(estadoJogo), 32'h0);
      tick();
    end
    keyEnterRaw = 1'b1;
    est_esp = 3'b000;
    $display("reset mid-GRAVA done, estado=%b", estadoJogo);
    pressiona(1'b1, 1'b0, 1'b1, 3'b001);
    $display("press after held release, estado=%b", estadoJogo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
